// File: rtl/s386_drv_pkg.sv
// Shared widths, response field layout and FSM states for the s386 stimulus driver.
package s386_drv_pkg;

  localparam int VEC_W        = 7;
  localparam int RSP_W        = 14;
  localparam int RSP_CMD_LSB  = 7;
  localparam int RSP_RESP_LSB = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

endpackage

// File: rtl/s386_rsp_fifo.sv
// Response FIFO holding {command, response} pairs; occupancy comes from the count,
// so the pointers are free to wrap naturally.
module s386_rsp_fifo
  import s386_drv_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             blif_clk_net,
  input  logic             blif_reset_net,
  input  logic             push,
  input  logic [RSP_W-1:0] push_data,
  input  logic             pop,
  output logic [RSP_W-1:0] head_data,
  output logic             head_valid,
  output logic             full,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [RSP_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full       = (count == FULL_CNT);
  assign head_valid = (count != '0);
  assign head_data  = mem[rd_ptr];
  assign do_push    = push && !full;
  assign do_pop     = pop && head_valid;

  // Storage is cleared on reset so the head reads as zero while empty after reset.
  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/s386_stim_driver.sv
// Drives one sequencer vector at a time onto the s386 controller inputs, holds it
// for HOLD_CYCLES clocks, then captures the controller outputs into the response FIFO.
module s386_stim_driver
  import s386_drv_pkg::*;
#(
  parameter int HOLD_CYCLES = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          blif_clk_net,
  input  logic                          blif_reset_net,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [VEC_W-1:0]              cmd_data,
  output logic [VEC_W-1:0]              drv_v,
  input  logic [VEC_W-1:0]              ctl_d,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [RSP_W-1:0]              rsp_data,
  output logic [$clog2(FIFO_DEPTH):0]   rsp_count
);

  localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES - 1);

  state_t           state;
  logic [3:0]       hold_cnt;
  logic [VEC_W-1:0] cur_cmd;
  logic             fifo_full;
  logic             push;
  logic [RSP_W-1:0] push_word;

  // Acceptance requires room in the FIFO, so the end-of-hold push can never overflow.
  assign cmd_ready = (state == IDLE) && !fifo_full && !blif_reset_net;
  assign push      = (state == DRIVE) && (hold_cnt == 4'd0);

  assign push_word[RSP_CMD_LSB  +: VEC_W] = cur_cmd;
  assign push_word[RSP_RESP_LSB +: VEC_W] = ctl_d;

  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      state    <= IDLE;
      drv_v    <= '0;
      cur_cmd  <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            drv_v    <= cmd_data;
            cur_cmd  <= cmd_data;
            hold_cnt <= HOLD_INIT;
            state    <= DRIVE;
          end
        end
        DRIVE: begin
          if (hold_cnt != 4'd0) hold_cnt <= hold_cnt - 1'b1;
          else                  state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  s386_rsp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .blif_clk_net   (blif_clk_net),
    .blif_reset_net (blif_reset_net),
    .push           (push),
    .push_data      (push_word),
    .pop            (rsp_ready),
    .head_data      (rsp_data),
    .head_valid     (rsp_valid),
    .full           (fifo_full),
    .count          (rsp_count)
  );

endmodule
